// File: rtl/enc_beat_scheduler_pkg.sv
// Shared phase encoding and default geometry for the RS encoder beat scheduler.
package enc_beat_scheduler_pkg;

   localparam int DEF_SYM      = 8;
   localparam int DEF_MES_LEN  = 239;
   localparam int DEF_PAR_LEN  = 16;
   localparam int DEF_CW_CNT_W = 16;

   localparam int DEF_COD_LEN  = DEF_MES_LEN + DEF_PAR_LEN;
   localparam int DEF_CW       = $clog2(DEF_COD_LEN);
   localparam int DEF_RW       = $clog2(DEF_SYM + 1);
   localparam int DEF_MW       = $clog2(DEF_MES_LEN + 1);

   typedef enum logic [2:0] {
      IDL = 3'd0,
      MES = 3'd1,
      MTP = 3'd2,
      PAR = 3'd3,
      PTM = 3'd4
   } sel_phase_e;

endpackage

// File: rtl/enc_beat_decode.sv
// Combinational beat decode: classifies the beat starting at position c of a
// codeword of length L and computes where the following beat starts.
module enc_beat_decode
   import enc_beat_scheduler_pkg::*;
#(
   parameter  int SYM     = DEF_SYM,
   parameter  int MES_LEN = DEF_MES_LEN,
   parameter  int PAR_LEN = DEF_PAR_LEN,
   localparam int COD_LEN = MES_LEN + PAR_LEN,
   localparam int CW      = $clog2(COD_LEN),
   localparam int RW      = $clog2(SYM + 1),
   localparam int MW      = $clog2(MES_LEN + 1),
   localparam int EW      = CW + 1
) (
   input  logic [CW-1:0] c_i,
   input  logic [MW-1:0] m_i,
   input  logic [EW-1:0] l_i,
   input  logic [MW-1:0] mn_i,
   output sel_phase_e    phase_o,
   output logic [RW-1:0] mes_req_o,
   output logic [RW-1:0] par_req_o,
   output logic          par_load_o,
   output logic          cw_last_o,
   output logic [CW-1:0] c_nxt_o,
   output logic [MW-1:0] m_nxt_o
);

   logic [EW-1:0] ce, cs, me;

   always_comb begin
      ce         = EW'(c_i);
      cs         = ce + EW'(SYM);
      me         = EW'(m_i);
      phase_o    = MES;
      mes_req_o  = RW'(SYM);
      par_req_o  = '0;
      par_load_o = 1'b0;
      cw_last_o  = 1'b0;
      // PAR_LEN >= SYM, so a beat crossing L always starts inside the parity
      if (cs > l_i) begin
         phase_o   = PTM;
         par_req_o = RW'(l_i - ce);
         mes_req_o = RW'(cs - l_i);
         cw_last_o = 1'b1;
      end else if (ce >= me) begin
         phase_o   = PAR;
         mes_req_o = '0;
         par_req_o = RW'(SYM);
         cw_last_o = (cs == l_i);
      end else if (cs > me) begin
         phase_o    = MTP;
         mes_req_o  = RW'(me - ce);
         par_req_o  = RW'(cs - me);
         par_load_o = 1'b1;
      end else begin
         par_load_o = (cs == me);
      end

      if (cs >= l_i) begin
         c_nxt_o = CW'(cs - l_i);
         m_nxt_o = mn_i;
      end else begin
         c_nxt_o = CW'(cs);
         m_nxt_o = m_i;
      end
   end

endmodule

// File: rtl/enc_beat_scheduler.sv
// RS encoder beat scheduler: packs codewords back-to-back onto SYM-wide beats.
// Optional per-codeword shortening via ENC_SCH_SHORTEN_EN (adds cfg_mes_len_i).
module enc_beat_scheduler
   import enc_beat_scheduler_pkg::*;
#(
   parameter  int SYM      = DEF_SYM,
   parameter  int MES_LEN  = DEF_MES_LEN,
   parameter  int PAR_LEN  = DEF_PAR_LEN,
   parameter  int CW_CNT_W = DEF_CW_CNT_W,
   localparam int COD_LEN  = MES_LEN + PAR_LEN,
   localparam int CW       = $clog2(COD_LEN),
   localparam int RW       = $clog2(SYM + 1),
   localparam int MW       = $clog2(MES_LEN + 1),
   localparam int EW       = CW + 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
`ifdef ENC_SCH_SHORTEN_EN
   input  logic [MW-1:0]       cfg_mes_len_i,
`endif
   input  logic                mes_valid_i,
   input  logic                out_ready_i,
   output logic                out_valid_o,
   output sel_phase_e          sel_phase_o,
   output logic [CW-1:0]       con_counter_o,
   output logic [RW-1:0]       mes_request_o,
   output logic [RW-1:0]       par_request_o,
   output logic                par_load_o,
   output logic                cw_last_o,
   output logic [CW_CNT_W-1:0] cw_count_o
);

   sel_phase_e          phase_q, phase_d;
   logic [CW-1:0]       c_q, c_d, c_nxt_q, c_nxt_d;
   logic [MW-1:0]       m_d, m_nxt_q, m_nxt_d, cfg_eff;
   logic [EW-1:0]       l_d;
   logic [RW-1:0]       mes_q, mes_d, par_q, par_d;
   logic                par_load_q, par_load_d, cw_last_q, cw_last_d;
   logic [CW_CNT_W-1:0] cw_cnt_q;
   logic                fire, load;

`ifdef ENC_SCH_SHORTEN_EN
   assign cfg_eff = (cfg_mes_len_i < MW'(SYM) || cfg_mes_len_i > MW'(MES_LEN))
                    ? MW'(MES_LEN) : cfg_mes_len_i;
`else
   assign cfg_eff = MW'(MES_LEN);
`endif

   assign out_valid_o = (phase_q != IDL) & ((mes_q == '0) | mes_valid_i);
   assign fire        = out_valid_o & out_ready_i;
   assign load        = (phase_q == IDL) | flush_i | fire;

   // A next start of 0 means a fresh codeword begins here, so sample its length now
   always_comb begin
      c_d = c_nxt_q;
      m_d = (c_nxt_q == '0) ? cfg_eff : m_nxt_q;
      if (phase_q == IDL || flush_i) begin
         c_d = '0;
         m_d = cfg_eff;
      end
   end

   assign l_d = EW'(m_d) + EW'(PAR_LEN);

   enc_beat_decode #(
      .SYM     (SYM),
      .MES_LEN (MES_LEN),
      .PAR_LEN (PAR_LEN)
   ) u_dec (
      .c_i        (c_d),
      .m_i        (m_d),
      .l_i        (l_d),
      .mn_i       (cfg_eff),
      .phase_o    (phase_d),
      .mes_req_o  (mes_d),
      .par_req_o  (par_d),
      .par_load_o (par_load_d),
      .cw_last_o  (cw_last_d),
      .c_nxt_o    (c_nxt_d),
      .m_nxt_o    (m_nxt_d)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         phase_q    <= IDL;
         c_q        <= '0;
         mes_q      <= '0;
         par_q      <= '0;
         par_load_q <= 1'b0;
         cw_last_q  <= 1'b0;
         cw_cnt_q   <= '0;
         c_nxt_q    <= '0;
         m_nxt_q    <= MW'(MES_LEN);
      end else if (load) begin
         phase_q    <= phase_d;
         c_q        <= c_d;
         mes_q      <= mes_d;
         par_q      <= par_d;
         par_load_q <= par_load_d;
         cw_last_q  <= cw_last_d;
         c_nxt_q    <= c_nxt_d;
         m_nxt_q    <= m_nxt_d;
         if (fire && cw_last_q && !flush_i)
            cw_cnt_q <= cw_cnt_q + CW_CNT_W'(1);
      end
   end

   assign sel_phase_o   = phase_q;
   assign con_counter_o = c_q;
   assign mes_request_o = mes_q;
   assign par_request_o = par_q;
   assign par_load_o    = par_load_q;
   assign cw_last_o     = cw_last_q;
   assign cw_count_o    = cw_cnt_q;

endmodule

// File: tb/tb_enc_beat_scheduler.sv
// Bench for enc_beat_scheduler: directed steps plus random traffic against a
// symbol-stream reference model.
module tb_enc_beat_scheduler;
   import enc_beat_scheduler_pkg::*;

   localparam int SYM     = 8;
   localparam int MES_LEN = 239;
   localparam int PAR_LEN = 16;
   localparam int CW      = $clog2(MES_LEN + PAR_LEN);
   localparam int RW      = $clog2(SYM + 1);
   localparam int MW      = $clog2(MES_LEN + 1);

   logic          clk = 1'b0;
   logic          rst, flush, mes_valid, out_ready;
   logic [MW-1:0] cfg;
   logic          out_valid, par_load, cw_last;
   sel_phase_e    sel_phase;
   logic [CW-1:0] con_counter;
   logic [RW-1:0] mes_request, par_request;
   logic [15:0]   cw_count;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state: start position, current message length, codewords done
   int m_c, m_M, m_cnt;

   typedef struct {
      int ph; int mes; int par; bit pl; bit last;
   } beat_t;

   always #5 clk = ~clk;

   enc_beat_scheduler u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .flush_i       (flush),
`ifdef ENC_SCH_SHORTEN_EN
      .cfg_mes_len_i (cfg),
`endif
      .mes_valid_i   (mes_valid),
      .out_ready_i   (out_ready),
      .out_valid_o   (out_valid),
      .sel_phase_o   (sel_phase),
      .con_counter_o (con_counter),
      .mes_request_o (mes_request),
      .par_request_o (par_request),
      .par_load_o    (par_load),
      .cw_last_o     (cw_last),
      .cw_count_o    (cw_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int eff_cfg();
`ifdef ENC_SCH_SHORTEN_EN
      return (int'(cfg) < SYM || int'(cfg) > MES_LEN) ? MES_LEN : int'(cfg);
`else
      return MES_LEN;
`endif
   endfunction

   // Walk the SYM symbols of the beat and classify each one
   function automatic beat_t model_beat(input int c, input int M);
      beat_t b;
      int    L = M + PAR_LEN;
      bit    cur_mes = 0, cur_par = 0, nxt = 0;
      b.mes = 0; b.pl = 0; b.last = 0;
      for (int k = 0; k < SYM; k++) begin
         int p = c + k;
         if (p < L) begin
            if (p < M) begin
               b.mes++; cur_mes = 1;
               if (p == M - 1) b.pl = 1;
            end else begin
               cur_par = 1;
               if (p == L - 1) b.last = 1;
            end
         end else begin
            nxt = 1; b.mes++;
         end
      end
      b.par = SYM - b.mes;
      b.ph  = nxt ? int'(PTM) : (cur_mes && cur_par) ? int'(MTP) :
              cur_par ? int'(PAR) : int'(MES);
      return b;
   endfunction

   task automatic drive_step(input bit mv, input bit rdy, input bit fl);
      beat_t b;
      bit    vexp;
      mes_valid = mv; out_ready = rdy; flush = fl;
      #1;
      b    = model_beat(m_c, m_M);
      vexp = (b.mes == 0) || mv;
      chk("phase",     sel_phase,   b.ph);
      chk("con_cnt",   con_counter, m_c);
      chk("mes_req",   mes_request, b.mes);
      chk("par_req",   par_request, b.par);
      chk("par_load",  par_load,    b.pl);
      chk("cw_last",   cw_last,     b.last);
      chk("cw_count",  cw_count,    m_cnt & 16'hFFFF);
      chk("out_valid", out_valid,   vexp);
      @(posedge clk);
      if (fl) begin
         m_c = 0; m_M = eff_cfg();
      end else if (rdy && vexp) begin
         if (b.last) m_cnt++;
         m_c = m_c + SYM;
         if (m_c >= m_M + PAR_LEN) begin
            m_c = m_c - (m_M + PAR_LEN);
            m_M = eff_cfg();
         end
      end
      #1;
      flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; mes_valid = 1'b1; out_ready = 1'b0;
      cfg = MW'(MES_LEN);
      m_c = 0; m_M = MES_LEN; m_cnt = 0;
      #12;
      chk("rst_phase",  sel_phase,   IDL);
      chk("rst_c",      con_counter, 0);
      chk("rst_mes",    mes_request, 0);
      chk("rst_par",    par_request, 0);
      chk("rst_pl",     par_load,    0);
      chk("rst_last",   cw_last,     0);
      chk("rst_cnt",    cw_count,    0);
      chk("rst_valid",  out_valid,   0);

      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      mes_valid = 1'b0; #1;
      chk("rel_phase",  sel_phase,   MES);
      chk("rel_c",      con_counter, 0);
      chk("rel_mes",    mes_request, 8);
      chk("rel_valid0", out_valid,   0);
      mes_valid = 1'b1; #1;
      chk("rel_valid1", out_valid,   1);

      for (int i = 0; i < 64 && m_c != 232; i++) drive_step(1, 1, 0);
      chk("c232_c", con_counter, 232);  chk("c232_ph", sel_phase, MTP);
      chk("c232_mes", mes_request, 7);  chk("c232_par", par_request, 1);
      chk("c232_pl", par_load, 1);
      drive_step(1, 1, 0);
      chk("c240_c", con_counter, 240);  chk("c240_ph", sel_phase, PAR);
      chk("c240_mes", mes_request, 0);  chk("c240_par", par_request, 8);
      drive_step(1, 1, 0);
      chk("c248_c", con_counter, 248);  chk("c248_ph", sel_phase, PTM);
      chk("c248_par", par_request, 7);  chk("c248_mes", mes_request, 1);
      chk("c248_last", cw_last, 1);     chk("c248_cnt", cw_count, 0);

      repeat (5) drive_step(1, 0, 0);
      chk("hold_c", con_counter, 248);  chk("hold_ph", sel_phase, PTM);
      chk("hold_cnt", cw_count, 0);     chk("hold_par", par_request, 7);
      drive_step(1, 1, 0);
      chk("wrap_c", con_counter, 1);    chk("wrap_cnt", cw_count, 1);

      for (int i = 0; i < 64 && m_c != 233; i++) drive_step(1, 1, 0);
      chk("c233_ph", sel_phase, MTP);
      chk("c233_mes", mes_request, 6);  chk("c233_par", par_request, 2);

      drive_step(1, 1, 1);
      chk("fl1_c", con_counter, 0);     chk("fl1_ph", sel_phase, MES);
      for (int i = 0; i < 64 && m_c != 120; i++) drive_step(1, 1, 0);
      chk("c120_c", con_counter, 120);
      drive_step(1, 1, 1);
      chk("fl2_c", con_counter, 0);     chk("fl2_ph", sel_phase, MES);
      chk("fl2_mes", mes_request, 8);   chk("fl2_cnt", cw_count, m_cnt);

      mes_valid = 1'b0; #1;
      chk("mesgap_valid", out_valid, 0);
      drive_step(0, 1, 0);
      chk("mesgap_c", con_counter, 0);

      for (int i = 0; i < 64 && m_c != 240; i++) drive_step(1, 1, 0);
      mes_valid = 1'b0; #1;
      chk("pargap_valid", out_valid, 1);
      drive_step(0, 1, 0);
      chk("pargap_c", con_counter, 248);

`ifdef ENC_SCH_SHORTEN_EN
      cfg = MW'(100);
      drive_step(1, 1, 1);
      for (int i = 0; i < 64 && m_c != 96; i++) drive_step(1, 1, 0);
      chk("s96_ph", sel_phase, MTP);
      chk("s96_mes", mes_request, 4);   chk("s96_par", par_request, 4);
      drive_step(1, 1, 0);
      drive_step(1, 1, 0);
      chk("s112_c", con_counter, 112);  chk("s112_ph", sel_phase, PTM);
      chk("s112_par", par_request, 4);  chk("s112_mes", mes_request, 4);
      cfg = MW'(3);
      drive_step(1, 1, 1);
      for (int i = 0; i < 64 && m_c != 232; i++) drive_step(1, 1, 0);
      chk("s3_c", con_counter, 232);    chk("s3_ph", sel_phase, MTP);
      chk("s3_mes", mes_request, 7);
`endif

      for (int i = 0; i < 1500; i++)
         drive_step(($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 200) == 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/enc_beat_scheduler.md
# enc_beat_scheduler

Beat scheduler for the Reed-Solomon encoder. It sequences message and parity symbols onto a SYM-symbol-wide output stream and packs codewords back-to-back, so a beat can straddle two codewords. It adds valid/ready backpressure, a synchronous flush, a codeword counter and, optionally, per-codeword runtime shortening. It drives the message buffer, parity generator and output selector.

## Interface
- `SYM`, 8: symbols per beat.
- `MES_LEN`, 239: maximum message length in symbols. Constraint: MES_LEN ≥ SYM.
- `PAR_LEN`, 16: parity length in symbols. Constraint: PAR_LEN ≥ SYM.
- `CW_CNT_W`, 16: width of the codeword counter.
- Derived: COD_LEN = MES_LEN + PAR_LEN; CW = $clog2(COD_LEN); RW = $clog2(SYM+1).
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous abort of the current codeword.
- `cfg_mes_len`  in  $clog2(MES_LEN+1)  shortened message length. Present only with ENC_SCH_SHORTEN_EN.
- `mes_valid`  in  1  message buffer holds ≥ mes_request symbols.
- `out_ready`  in  1  downstream accepts the beat.
- `out_valid`  out  1  current beat descriptor valid.
- `sel_phase`  out  SEL_PHASE  one of IDL, MES, MTP, PAR, PTM.
- `con_counter`  out  CW  position within the codeword of the beat's first symbol.
- `mes_request`  out  RW  message symbols in the beat.
- `par_request`  out  RW  parity symbols in the beat; always SYM − mes_request, except 0 in IDL.
- `par_load`  out  1  beat carries the codeword's last message symbol; parity generator latches its result.
- `cw_last`  out  1  beat carries the codeword's last symbol.
- `cw_count`  out  CW_CNT_W  completed codewords; wraps.

## Operation
- Let c = con_counter, M = current message length, L = M + PAR_LEN, M' = message length of the next codeword.
- Phase decode:
  - MES if c + SYM ≤ M.
  - MTP if c < M < c + SYM; mes_request = M − c.
  - PAR if c ≥ M and c + SYM ≤ L.
  - PTM if c + SYM > L; par_request = L − c, mes_request = c + SYM − L. These message symbols belong to the next codeword.
- par_load = 1 on MTP, or on MES with c + SYM == M.
- cw_last = 1 on PTM, or on PAR with c + SYM == L.
- Advance: next c = c + SYM if c + SYM < L; otherwise c + SYM − L, with L then taken from M'.
- fire = out_valid & out_ready. All outputs hold when fire = 0.
- out_valid = (mes_request == 0) | mes_valid, gated 0 in IDL. This path is combinational from mes_valid.
- cw_count increments on a fire with cw_last = 1.
- State machine:
  - IDL: entered from reset. The first clock after reset deasserts loads the c = 0 beat and moves to run.
  - Run: MES/MTP/PAR/PTM as decoded. There is no return to IDL except through rst.
- flush: the next edge loads the c = 0 beat and drops the partial codeword. cw_count is unchanged. flush wins over a simultaneous fire.
- Stream gap after flush: an in-flight PTM head is discarded.

## Timing
- All outputs are registered except out_valid.
- Reset values: sel_phase = IDL, con_counter = 0, mes_request = 0, par_request = 0, par_load = 0, cw_last = 0, cw_count = 0, out_valid = 0.
- Latency: the first beat descriptor is valid 1 cycle after rst deasserts. Each fire loads the next beat on the same edge. One beat per cycle under continuous fire.
- Backpressure: holding out_ready = 0 keeps every output stable indefinitely.

## Configuration
- Macro: `ENC_SCH_SHORTEN_EN`.
- Defined:
  - The cfg_mes_len port exists.
  - M' is sampled on the edge that loads the beat containing the next codeword's first symbol (the c = 0 load or the PTM load).
  - Values < SYM or > MES_LEN are treated as MES_LEN.
- Undefined: the port is absent and M = M' = MES_LEN constant.

## Structure
- Shared package (encoder.vh) carries:
  - the SEL_PHASE enum (IDL, MES, MTP, PAR, PTM);
  - SYM/MES_LEN/PAR_LEN defaults;
  - the derived-width localparams.
- One combinational sub-module, `enc_beat_decode`:
  - inputs: c, M, L, M';
  - outputs: phase, mes_request, par_request, par_load, cw_last, next c.
- The top module holds the registers, handshake, flush and counters.

## Test plan
- Defaults, no backpressure:
  - c = 232 → MTP, mes 7 / par 1, par_load;
  - c = 240 → PAR 0/8;
  - c = 248 → PTM par 7 / mes 1, cw_last, cw_count 0→1;
  - next c = 1; c = 233 → MTP mes 6 / par 2.
- Reset release: the cycle after rst deasserts shows sel_phase MES, c = 0, mes_request 8, out_valid = mes_valid.
- out_ready = 0 for 5 cycles during a PTM beat → all outputs frozen; cw_count increments only on the single fire.
- flush at c = 120 together with out_ready = 1 → next beat c = 0, MES, cw_count unchanged.
- SHORTEN_EN with cfg_mes_len = 100:
  - L = 116; c = 96 → MTP mes 4 / par 4;
  - c = 112 → PTM par 4 / mes 4;
  - cfg_mes_len = 3 → behaves as 239.
- mes_valid = 0 on a PAR beat → out_valid = 1 and the beat fires; on a MES beat → out_valid = 0 and no advance.
